// File: rtl/hazard_controller_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control types and constants
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} hz_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/hazard_controller_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  // clear wins over increment; hold once all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush sequencing for the five-stage pipeline
module hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_e,
  input  logic             memread_e,
  input  logic             branch_taken_e,
  input  logic             dmem_req_m,
  input  logic             dmem_ready_m,
  input  logic             counter_clr,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam int WW = $clog2(TIMEOUT + 1);
  hz_state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_cnt_nx;
  logic memwait, loaduse, halt, br_flush;
  assign memwait  = dmem_req_m & ~dmem_ready_m;
  assign loaduse  = memread_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
  assign halt     = (state == FAULT) | memwait;
  assign br_flush = rst_n & ~halt & branch_taken_e;
  assign mem_timeout = state == FAULT;
  // priority-ordered Mealy controls: reset, fault/memwait, branch, load-use
  always_comb
    {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w} =
      !rst_n         ? 7'b0000_111 :
      halt           ? 7'b1111_001 :
      branch_taken_e ? 7'b0000_110 :
      loaduse        ? 7'b1100_010 : 7'b0000_000;
  // wait tracking: leaving MEM_WAIT on ready or withdrawn request, fault at the limit
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    if (state == RUN && memwait) begin
      state_nx    = MEM_WAIT;
      wait_cnt_nx = WW'(1);
    end else if (state == MEM_WAIT) begin
      if (!memwait) begin
        state_nx    = RUN;
        wait_cnt_nx = '0;
      end else if (wait_cnt == WW'(TIMEOUT)) state_nx = FAULT;
      else wait_cnt_nx = wait_cnt + 1'b1;
    end
  end
  // state and wait counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(counter_clr), .inc(stall_f), .q(stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr(counter_clr), .inc(br_flush), .q(flush_count)
  );
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vector bench for hazard_controller
module tb_hazard_controller;
  logic clk = 0, rst_n = 0;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic memread_e, branch_taken_e, dmem_req_m, dmem_ready_m, counter_clr;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout;
  logic [3:0] stall_cycles, flush_count;
  logic [6:0] ctl;
  int n_cmp = 0, n_bad = 0;

  hazard_controller #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .memread_e(memread_e), .branch_taken_e(branch_taken_e),
    .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m), .counter_clr(counter_clr),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
  always #5 clk = ~clk;

  typedef struct {
    logic mr; logic [4:0] rd, r1, r2; logic br, rq, ry;
    logic [6:0] ctl; int st, fl;
  } vec_t;
  vec_t v[9];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic set(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                     input logic [4:0] r2, input logic br, input logic rq,
                     input logic ry, input logic cl);
    memread_e = mr; rd_e = rd; rs1_d = r1; rs2_d = r2;
    branch_taken_e = br; dmem_req_m = rq; dmem_ready_m = ry; counter_clr = cl;
  endtask

  task automatic cnts(input string nm, input int st, input int fl);
    chk({nm, "_stall_cycles"}, 32'(stall_cycles), 32'(st));
    chk({nm, "_flush_count"}, 32'(flush_count), 32'(fl));
  endtask

  initial begin
    v[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0000_000, 0, 0};
    v[1] = '{1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 7'b1100_010, 1, 0};
    v[2] = '{1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b0, 7'b1100_010, 2, 0};
    v[3] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 7'b0000_000, 2, 0};
    v[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 7'b0000_000, 2, 0};
    v[5] = '{1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 7'b0000_110, 2, 1};
    v[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 7'b0000_110, 2, 2};
    v[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 7'b0000_000, 2, 2};
    v[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 7'b0000_110, 2, 3};
    set(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_ctl", 32'(ctl), 32'(7'b0000_111));
    chk("rst_timeout", 32'(mem_timeout), 0);
    cnts("rst", 0, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 9; i++) begin
      set(v[i].mr, v[i].rd, v[i].r1, v[i].r2, v[i].br, v[i].rq, v[i].ry, 0);
      #1 chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(v[i].ctl));
      @(negedge clk);
      cnts($sformatf("vec%0d", i), v[i].st, v[i].fl);
    end
    set(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    cnts("clr", 0, 0);
    for (int k = 0; k < 3; k++) begin
      set(0, 0, 0, 0, 1, 1, 0, 0);
      #1 chk($sformatf("mw_hold%0d", k), 32'(ctl), 32'(7'b1111_001));
      @(negedge clk);
    end
    set(0, 0, 0, 0, 1, 1, 1, 0);
    #1 chk("mw_release", 32'(ctl), 32'(7'b0000_110));
    @(negedge clk);
    set(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("mw_after", 32'(ctl), 0);
    cnts("mw", 3, 1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      set(0, 0, 0, 0, 0, 1, 0, 0);
      #1 chk($sformatf("wd_hold%0d", k), 32'(ctl), 32'(7'b1111_001));
      @(negedge clk);
    end
    set(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("wd_release", 32'(ctl), 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      set(0, 0, 0, 0, 0, 1, 0, 0);
      #1 chk($sformatf("lim_hold%0d", k), 32'(ctl), 32'(7'b1111_001));
      @(negedge clk);
    end
    set(0, 0, 0, 0, 0, 1, 1, 0);
    #1 chk("lim_ready", 32'(ctl), 0);
    @(negedge clk);
    set(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lim_no_fault", 32'(mem_timeout), 0);
    chk("lim_run_ctl", 32'(ctl), 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      set(0, 0, 0, 0, 0, 1, 0, 0);
      #1 chk($sformatf("to_wait%0d_ctl", k), 32'(ctl), 32'(7'b1111_001));
      chk($sformatf("to_wait%0d_flag", k), 32'(mem_timeout), 0);
      @(negedge clk);
    end
    set(0, 0, 0, 0, 1, 0, 0, 0);
    #1 chk("fault_flag", 32'(mem_timeout), 1);
    chk("fault_ctl", 32'(ctl), 32'(7'b1111_001));
    @(negedge clk);
    set(1, 5, 5, 0, 0, 1, 1, 0);
    #1 chk("fault_sticky", 32'(mem_timeout), 1);
    chk("fault_ctl2", 32'(ctl), 32'(7'b1111_001));
    #2 rst_n = 0;
    #1 chk("fault_rst_flag", 32'(mem_timeout), 0);
    chk("fault_rst_ctl", 32'(ctl), 32'(7'b0000_111));
    @(negedge clk) rst_n = 1;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("post_rst_ctl", 32'(ctl), 0);
    cnts("post_rst", 0, 0);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      set(1, 9, 9, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    cnts("sat_stall", 15, 0);
    set(1, 9, 9, 0, 0, 0, 0, 1);
    #1 chk("clr_stall_ctl", 32'(ctl), 32'(7'b1100_010));
    @(negedge clk);
    cnts("clr_stall", 0, 0);
    for (int k = 0; k < 20; k++) begin
      set(0, 0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
    end
    cnts("sat_flush", 0, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the five-stage core. Each cycle it generates the stall (hold) and flush (insert-NOP) controls for the fetch, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits. It also keeps saturating stall and flush performance counters and latches a sticky fault on a memory timeout.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.
- TIMEOUT, 255, maximum tolerated consecutive memory-wait cycles before fault (≥1).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_d, rs2_d  in  5  source register indices of the instruction in decode.
- rd_e  in  5  destination register index of the instruction in execute.
- memread_e  in  1  execute-stage instruction is a load.
- branch_taken_e  in  1  execute-stage branch/jump resolved taken.
- dmem_req_m  in  1  memory stage has an outstanding data-memory access.
- dmem_ready_m  in  1  data memory completes the access this cycle.
- counter_clr  in  1  synchronous clear of both performance counters.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID (drives the decode register's enable; 1 = hold).
- stall_e, stall_m  out  1  hold ID/EX, EX/MEM.
- flush_d  out  1  clear IF/ID to NOP 32'h00000013 (clear dominates hold).
- flush_e, flush_w  out  1  insert bubble into ID/EX, MEM/WB.
- mem_timeout  out  1  sticky fault flag.
- stall_cycles, flush_count  out  CNT_W  saturating counters.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Register wait_cnt is $clog2(TIMEOUT+1) bits wide.
- The hazard terms are combinational:
  - memwait = dmem_req_m & ~dmem_ready_m.
  - loaduse = memread_e & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d).
- Outputs are Mealy, evaluated in strict priority:
  - 1. rst_n=0: flush_d=flush_e=flush_w=1, all stalls 0.
  - 2. state FAULT: stall_f/d/e/m=1, flush_w=1, other flushes 0.
  - 3. memwait (in RUN or MEM_WAIT): stall_f/d/e/m=1, flush_w=1, flush_d=flush_e=0. A branch in EX is held, not acted on.
  - 4. branch_taken_e: flush_d=flush_e=1, all stalls 0. This overrides loaduse so the PC takes the target.
  - 5. loaduse: stall_f=stall_d=1, flush_e=1.
  - 6. Otherwise all 0.
- State transitions:
  - RUN with memwait → MEM_WAIT, wait_cnt←1.
  - MEM_WAIT with dmem_ready_m → RUN, wait_cnt←0.
  - MEM_WAIT with memwait and wait_cnt==TIMEOUT → FAULT.
  - MEM_WAIT with memwait otherwise: wait_cnt++.
  - MEM_WAIT with dmem_req_m=0 (request withdrawn) → RUN, wait_cnt←0.
  - FAULT is terminal until reset.
- mem_timeout=1 exactly when state==FAULT.
- Counters:
  - stall_cycles increments on every cycle with stall_f=1.
  - flush_count increments on every cycle where priority 4 is active.
  - Both saturate at all-ones and never wrap.
  - counter_clr takes priority over increment that cycle (value becomes 0).

## Timing
- Control outputs are combinational, valid in the same cycle as their inputs, with zero latency to the pipeline registers.
- Reset values: state RUN, wait_cnt 0, counters 0, mem_timeout 0.
- Reset asserted mid-MEM_WAIT or in FAULT returns immediately to RUN.
- dmem_ready_m in the same cycle as the first request: no stall, state stays RUN.
- Ready on the wait_cnt==TIMEOUT cycle: the access completes and the block returns to RUN, not FAULT.
- FAULT is entered at the edge closing the (TIMEOUT+1)th consecutive wait cycle. From the next cycle all stalls are held.
- Load-use produces exactly one bubble per dependent pair. The next cycle the load has left EX, so loaduse=0.

## Structure
- Package pipe_ctrl_pkg: state enum hz_state_t {RUN, MEM_WAIT, FAULT} and constant NOP_INSTR = 32'h00000013 (shared with the decode stage).
- One sub-module, sat_counter (parameter W; inputs clr, inc), instantiated twice for the performance counters.

## Test plan
- Reset: hold rst_n=0 → flush_d=flush_e=flush_w=1, stalls 0. Release → counters 0, mem_timeout 0.
- Load-use: memread_e=1, rd_e=5, rs2_d=5 → for one cycle stall_f=stall_d=flush_e=1; stall_cycles=1. With rd_e=0 → no stall.
- Branch during load-use: both conditions true → flush_d=flush_e=1, stall_f=0; flush_count increments by 1.
- Memory wait: dmem_req_m=1 with ready low for 3 cycles, then high → stalls asserted for 3 cycles, released on the ready cycle, state back to RUN; a branch held in EX flushes only after release.
- Timeout (TIMEOUT=4): ready never asserted → FAULT after 5 wait cycles, mem_timeout=1 and stays stuck; reset clears it.
- Saturation (CNT_W=4): 20 stall cycles → stall_cycles=15. Assert counter_clr together with a stall → value 0.
